// File: rtl/mar_ram_if.sv
// W-bus and program-port signal bundle for the SAP-1 MAR/RAM block.
// The master side drives control, address and write requests.
// The slave side (mar_ram) returns read data, handshake status and debug state.
interface mar_ram_if #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
);
  logic                  Lm_n;
  logic                  Ce_n;
  logic [ADDR_WIDTH-1:0] w_bus_addr;
  logic [DATA_WIDTH-1:0] w_bus_data;
  logic                  w_bus_data_oe;
  logic                  prog_en;
  logic                  prog_valid;
  logic [ADDR_WIDTH-1:0] prog_addr;
  logic [DATA_WIDTH-1:0] prog_data;
  logic                  prog_ready;
  logic                  prog_mode;
  logic [ADDR_WIDTH-1:0] mar_q;
  logic [ADDR_WIDTH:0]   prog_count;

  modport master (
    output Lm_n, Ce_n, w_bus_addr, prog_en, prog_valid, prog_addr, prog_data,
    input  w_bus_data, w_bus_data_oe, prog_ready, prog_mode, mar_q, prog_count
  );

  modport slave (
    input  Lm_n, Ce_n, w_bus_addr, prog_en, prog_valid, prog_addr, prog_data,
    output w_bus_data, w_bus_data_oe, prog_ready, prog_mode, mar_q, prog_count
  );
endinterface

// File: rtl/mar_ram.sv
// SAP-1 memory address register plus 2**ADDR_WIDTH x DATA_WIDTH RAM.
// Read path is combinational from MAR; MAR load and RAM write take effect at the next edge.
// Program port accepts one write per two cycles (ready drops for one recovery cycle).
module mar_ram #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic        CLK_n,
  input  logic        CLR,
  mar_ram_if.slave    bus
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] CNT_MAX = {1'b1, {ADDR_WIDTH{1'b0}}};

  typedef enum logic [1:0] {
    RUN       = 2'd0,
    PROG_IDLE = 2'd1,
    PROG_WR   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // State, MAR and write counter registers; CLR overrides everything.
  always_ff @(posedge CLK_n) begin
    if (CLR) begin
      state_q <= RUN;
      addr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      count_q <= count_d;
    end
  end

  // Next-state logic: bus operations in RUN take precedence over a mode request.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    count_d = count_q;
    wr_en   = 1'b0;
    unique case (state_q)
      RUN: begin
        if (!bus.Lm_n) begin
          addr_d = bus.w_bus_addr;
        end
        if (bus.prog_en && bus.Lm_n && bus.Ce_n) begin
          state_d = PROG_IDLE;
          count_d = '0;
        end
      end
      PROG_IDLE: begin
        if (bus.prog_valid) begin
          wr_en   = 1'b1;
          addr_d  = bus.prog_addr;
          count_d = (count_q == CNT_MAX) ? count_q : count_q + 1'b1;
          state_d = PROG_WR;
        end else if (!bus.prog_en) begin
          state_d = RUN;
        end
      end
      PROG_WR: begin
        state_d = bus.prog_en ? PROG_IDLE : RUN;
      end
      default: begin
        state_d = RUN;
      end
    endcase
  end

  // RAM write port; not reset, and a write colliding with CLR is dropped.
  always_ff @(posedge CLK_n) begin
    if (wr_en && !CLR) begin
      mem[bus.prog_addr] <= bus.prog_data;
    end
  end

  assign bus.prog_ready    = (state_q == PROG_IDLE);
  assign bus.prog_mode     = (state_q != RUN);
  assign bus.w_bus_data_oe = (state_q == RUN) && !bus.Ce_n;
  assign bus.w_bus_data    = bus.w_bus_data_oe ? mem[addr_q] : '0;
  assign bus.mar_q         = addr_q;
  assign bus.prog_count    = count_q;

endmodule

// File: tb/tb_mar_ram.sv
// Bench for mar_ram: directed W-bus and program-port sequences.
// A mode/memory model tracks what the block must show; outputs are compared every falling edge.
// Hand-computed literal expectations pin down the key scenarios.
module tb_mar_ram;

  logic CLK_n = 1'b0;
  logic CLR;
  int   total = 0;
  int   bad   = 0;

  mar_ram_if #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) bus ();

  mar_ram #(.ADDR_WIDTH(4), .DATA_WIDTH(8)) dut (
    .CLK_n (CLK_n),
    .CLR   (CLR),
    .bus   (bus)
  );

  always #5 CLK_n = ~CLK_n;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: mode 0 = running, 1 = waiting for a write, 2 = write recovery.
  int         m_mode = 0;
  logic [3:0] m_mar  = 4'h0;
  int         m_cnt  = 0;
  logic [7:0] m_mem [16];
  bit         m_known [16];
  bit         started = 1'b0;

  always @(posedge CLK_n) begin
    if (CLR) begin
      m_mode  = 0;
      m_mar   = 4'h0;
      m_cnt   = 0;
      started = 1'b1;
    end else if (m_mode == 0) begin
      if (!bus.Lm_n) m_mar = bus.w_bus_addr;
      if (bus.prog_en && bus.Lm_n && bus.Ce_n) begin
        m_mode = 1;
        m_cnt  = 0;
      end
    end else if (m_mode == 1) begin
      if (bus.prog_valid) begin
        m_mem[bus.prog_addr]   = bus.prog_data;
        m_known[bus.prog_addr] = 1'b1;
        m_mar  = bus.prog_addr;
        m_cnt  = (m_cnt < 16) ? m_cnt + 1 : 16;
        m_mode = 2;
      end else if (!bus.prog_en) begin
        m_mode = 0;
      end
    end else begin
      m_mode = bus.prog_en ? 1 : 0;
    end
  end

  // Compare process: outputs are stable at the falling edge.
  always @(negedge CLK_n) begin
    if (started) begin
      automatic bit oe_exp = (m_mode == 0) && !bus.Ce_n;
      check("ready", 32'(bus.prog_ready), 32'(m_mode == 1));
      check("mode", 32'(bus.prog_mode), 32'(m_mode != 0));
      check("oe", 32'(bus.w_bus_data_oe), 32'(oe_exp));
      check("mar", 32'(bus.mar_q), 32'(m_mar));
      check("count", 32'(bus.prog_count), 32'(m_cnt));
      if (!oe_exp) check("data_idle", 32'(bus.w_bus_data), 32'h0);
      else if (m_known[m_mar]) check("data", 32'(bus.w_bus_data), 32'(m_mem[m_mar]));
    end
  end

  task automatic tick();
    @(posedge CLK_n);
    #1;
  endtask

  int accepts = 0;
  logic [6:0] rdy_pat = '0;
  int pat_n = 0;

  // Present a write and hold it until ready is seen at an edge.
  task automatic prog_write(input logic [3:0] a, input logic [7:0] d, input bit record);
    bit got;
    int n;
    bus.prog_valid = 1'b1;
    bus.prog_addr  = a;
    bus.prog_data  = d;
    n = 0;
    got = 1'b0;
    while (!got && n < 20) begin
      got = bus.prog_ready;
      if (record && pat_n < 7) begin
        rdy_pat = {rdy_pat[5:0], bus.prog_ready};
        pat_n++;
      end
      if (got) accepts++;
      tick();
      n++;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL handshake_timeout: addr %0h never accepted (ready=%0b)", a, bus.prog_ready);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    CLR = 1'b1;
    bus.Lm_n = 1'b1;
    bus.Ce_n = 1'b1;
    bus.w_bus_addr = 4'h0;
    bus.prog_en = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_addr = 4'h0;
    bus.prog_data = 8'h00;
    for (int i = 0; i < 16; i++) m_known[i] = 1'b0;
    tick();
    CLR = 1'b0;

    // Put MAR at A, then reset for two cycles.
    bus.Lm_n = 1'b0;
    bus.w_bus_addr = 4'hA;
    tick();
    bus.Lm_n = 1'b1;
    check("pre_reset_mar", 32'(bus.mar_q), 32'hA);
    CLR = 1'b1;
    tick();
    tick();
    check("reset_mar", 32'(bus.mar_q), 32'h0);
    check("reset_oe", 32'(bus.w_bus_data_oe), 32'h0);
    check("reset_ready", 32'(bus.prog_ready), 32'h0);
    check("reset_mode", 32'(bus.prog_mode), 32'h0);
    CLR = 1'b0;

    // Program four words with valid held continuously.
    bus.prog_en = 1'b1;
    tick();
    prog_write(4'h0, 8'h09, 1'b1);
    prog_write(4'h1, 8'h1A, 1'b1);
    prog_write(4'h2, 8'h2B, 1'b1);
    prog_write(4'hF, 8'hE0, 1'b1);
    bus.prog_valid = 1'b0;
    check("accepts", 32'(accepts), 32'd4);
    check("ready_pattern", 32'(rdy_pat), 32'b1010101);
    tick();
    check("prog_count4", 32'(bus.prog_count), 32'd4);
    check("prog_mar_F", 32'(bus.mar_q), 32'hF);
    check("in_prog_idle", 32'(bus.prog_ready), 32'h1);
    bus.prog_en = 1'b0;
    tick();
    check("back_to_run", 32'(bus.prog_mode), 32'h0);
    check("count_held", 32'(bus.prog_count), 32'd4);

    // Fetch address 1.
    bus.w_bus_addr = 4'h1;
    bus.Lm_n = 1'b0;
    tick();
    bus.Lm_n = 1'b1;
    bus.Ce_n = 1'b0;
    #1;
    check("fetch_mar", 32'(bus.mar_q), 32'h1);
    check("fetch_oe", 32'(bus.w_bus_data_oe), 32'h1);
    check("fetch_data", 32'(bus.w_bus_data), 32'h1A);
    bus.Ce_n = 1'b1;

    // Simultaneous load and read.
    bus.w_bus_addr = 4'h2;
    bus.Lm_n = 1'b0;
    tick();
    bus.w_bus_addr = 4'hF;
    bus.Ce_n = 1'b0;
    #1;
    check("simul_before", 32'(bus.w_bus_data), 32'h2B);
    tick();
    bus.Lm_n = 1'b1;
    #1;
    check("simul_mar", 32'(bus.mar_q), 32'hF);
    check("simul_after", 32'(bus.w_bus_data), 32'hE0);

    // Mode guard: a bus read blocks the mode change.
    bus.prog_en = 1'b1;
    tick();
    tick();
    check("guard_mode", 32'(bus.prog_mode), 32'h0);
    check("guard_oe", 32'(bus.w_bus_data_oe), 32'h1);
    bus.Ce_n = 1'b1;
    tick();
    check("guard_enter", 32'(bus.prog_mode), 32'h1);
    bus.w_bus_addr = 4'h5;
    bus.Lm_n = 1'b0;
    tick();
    bus.Lm_n = 1'b1;
    tick();
    bus.Lm_n = 1'b0;
    tick();
    bus.Lm_n = 1'b1;
    check("guard_mar", 32'(bus.mar_q), 32'hF);

    // Reset colliding with a write.
    prog_write(4'h3, 8'h33, 1'b0);
    bus.prog_valid = 1'b0;
    tick();
    bus.prog_valid = 1'b1;
    bus.prog_addr = 4'h3;
    bus.prog_data = 8'h77;
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    bus.prog_valid = 1'b0;
    bus.prog_en = 1'b0;
    check("clr_mode", 32'(bus.prog_mode), 32'h0);
    check("clr_count", 32'(bus.prog_count), 32'd0);
    bus.w_bus_addr = 4'h3;
    bus.Lm_n = 1'b0;
    tick();
    bus.Lm_n = 1'b1;
    bus.Ce_n = 1'b0;
    #1;
    check("clr_mem3", 32'(bus.w_bus_data), 32'h33);
    bus.Ce_n = 1'b1;

    // Seventeen writes: the counter saturates at 16.
    bus.prog_en = 1'b1;
    tick();
    for (int i = 0; i < 17; i++) prog_write(4'(i), 8'(8'h40 + i), 1'b0);
    bus.prog_valid = 1'b0;
    bus.prog_en = 1'b0;
    tick();
    tick();
    check("count_sat", 32'(bus.prog_count), 32'd16);
    bus.w_bus_addr = 4'h0;
    bus.Lm_n = 1'b0;
    tick();
    bus.Lm_n = 1'b1;
    bus.Ce_n = 1'b0;
    #1;
    check("wrap_write", 32'(bus.w_bus_data), 32'h50);
    bus.Ce_n = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mar_ram.md
Name: mar_ram

Overview:
- SAP-1 memory address register plus 16x8 program/data RAM.
- Consumes the address the program counter drives onto the W bus: latches it on Lm_n and returns the addressed byte to the W bus on Ce_n.
- Also provides a program-mode write port with a valid/ready handshake, so the bench or loader can fill RAM before the run starts.

Parameters:
ADDR_WIDTH, 4, MAR width; RAM depth = 2**ADDR_WIDTH
DATA_WIDTH, 8, RAM word and W-bus width

Ports:
CLK_n  input  1  system clock; all state updates on rising edge of CLK_n
CLR  input  1  synchronous active-high reset
Lm_n  input  1  active-low: load MAR from w_bus_addr at the next edge
Ce_n  input  1  active-low: drive mem[MAR] onto the W bus
w_bus_addr  input  ADDR_WIDTH  low bits of W bus (PC or IR address field)
w_bus_data  output  DATA_WIDTH  RAM read data toward W bus
w_bus_data_oe  output  1  high when w_bus_data is valid and must be driven
prog_en  input  1  request program mode
prog_valid  input  1  write request valid
prog_addr  input  ADDR_WIDTH  write address
prog_data  input  DATA_WIDTH  write data
prog_ready  output  1  write port can accept a request this cycle
prog_mode  output  1  block is in program mode (PROG_IDLE or PROG_WR)
mar_q  output  ADDR_WIDTH  current MAR contents (debug/bench)
prog_count  output  ADDR_WIDTH+1  writes accepted since the last entry into program mode

Behaviour:
Reset (CLR high at an edge):
- state=RUN, MAR=0, prog_count=0.
- Outputs: prog_ready=0, prog_mode=0, w_bus_data_oe=0, w_bus_data=0.
- RAM contents are not changed by CLR.
- CLR has priority over every other input. A write presented on the same edge as CLR is dropped.

FSM states: RUN, PROG_IDLE, PROG_WR.

RUN:
- Lm_n=0 at an edge -> MAR <= w_bus_addr.
- Ce_n=0 (combinational) -> w_bus_data_oe=1 and w_bus_data=mem[MAR]. Otherwise oe=0 and data=0.
- Lm_n=0 and Ce_n=0 together: read uses the pre-edge MAR value, then MAR updates at the edge.
- prog_en=1 and both Lm_n and Ce_n high -> PROG_IDLE and prog_count <= 0.
- prog_en=1 while Lm_n or Ce_n is low -> the bus operation wins, no transition. Re-evaluated each cycle.

PROG_IDLE:
- prog_ready=1, prog_mode=1. Lm_n and Ce_n are ignored; oe=0.
- prog_valid=1 -> mem[prog_addr] <= prog_data, MAR <= prog_addr, prog_count += 1 (saturates at 2**ADDR_WIDTH), go to PROG_WR.
- prog_valid=0 and prog_en=0 -> RUN.
- prog_valid=1 and prog_en=0 on the same edge -> the write is still accepted, then go to PROG_WR.

PROG_WR:
- One-cycle recovery: prog_ready=0, prog_mode=1.
- Next edge: prog_en=1 -> PROG_IDLE; prog_en=0 -> RUN.
- Handshake cost: one write per two cycles.
- prog_valid held high during PROG_WR is not a new transfer. The requester must hold valid/addr/data until it sees ready=1 at an edge.

Other rules:
- Address wraps naturally; there are no out-of-range addresses.
- prog_count holds its last value after returning to RUN.

Test Plan:
- Reset: CLR=1 for 2 cycles with MAR previously at 4'hA -> mar_q=0, oe=0, prog_ready=0, prog_mode=0.
- Program: prog_en=1, then four writes 0:8'h09, 1:8'h1A, 2:8'h2B, F:8'hE0, valid held continuously -> exactly 4 accepts, ready pattern 1,0,1,0..., prog_count=4, mar_q=F; drop prog_en -> RUN within 1 cycle of PROG_IDLE.
- Fetch: in RUN, w_bus_addr=1 with Lm_n=0 for one edge, then Ce_n=0 -> mar_q=1, oe=1, w_bus_data=8'h1A.
- Simultaneous: MAR=2, w_bus_addr=F, Lm_n=0 and Ce_n=0 -> data 8'h2B before the edge; mar_q=F and data 8'hE0 after.
- Mode guard: prog_en=1 while Ce_n=0 -> stays RUN and oe remains 1; Ce_n released -> PROG_IDLE next edge; Lm_n pulses with w_bus_addr=5 in PROG_IDLE leave mar_q unchanged.
- Reset mid-write: in PROG_IDLE, prog_valid=1 with addr 3, data 8'h77, and CLR=1 on the same edge -> mem[3] unchanged (read back via fetch), state RUN, prog_count=0.
